// File: rtl/lsu_sequencer.sv
// -----------------------------------------------------------------------------
// lsu_sequencer
//   Multicycle load/store sequencer between the datapath and a 64-bit data
//   memory. Accepts one byte-addressed request at a time, fetches the aligned
//   doubleword for loads and sub-doubleword stores (read-modify-write), writes
//   full doublewords directly, and returns a one-cycle response pulse.
//
//   Optional feature (macro LSU_FORWARD_EN): one-entry buffer holding the last
//   written doubleword; a load hitting it answers in the next cycle without a
//   memory read. With the macro undefined every load reads memory.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   req_valid/ready   request handshake, ready only while idle
//   req_we/size/unsigned/addr/wdata  request fields, latched on accept
//   mem_addr          doubleword-aligned memory address
//   mem_rd, mem_wr    one-cycle read / write strobes
//   mem_wdata         full doubleword write data
//   mem_rdata         read data, valid MEM_LAT cycles after mem_rd
//   resp_valid        one-cycle completion pulse
//   resp_rdata        extended load data (0 for stores and errors)
//   resp_err          misaligned access, qualified by resp_valid
// -----------------------------------------------------------------------------
module lsu_sequencer #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR, RESP} state_t;

  localparam logic [2:0] LAST_WAIT = 3'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q;
  logic              we_q, uns_q;
  logic [1:0]        size_q;
  logic [2:0]        off_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept, misaligned, wait_done;
  logic [ADDR_W-1:0] dw_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  // Shift the addressed field down to bit 0, then truncate and extend.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] dw,
                                                    input logic [2:0] off,
                                                    input logic [1:0] size,
                                                    input logic uns);
    logic [DATA_W-1:0] f;
    f = dw >> {off, 3'b000};
    case (size)
      2'd0:    load_extend = {{(DATA_W-8){~uns & f[7]}},   f[7:0]};
      2'd1:    load_extend = {{(DATA_W-16){~uns & f[15]}}, f[15:0]};
      2'd2:    load_extend = {{(DATA_W-32){~uns & f[31]}}, f[31:0]};
      default: load_extend = f;
    endcase
  endfunction

  // Replace bytes [off, off+2^size-1] of the old doubleword with store data.
  function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] old,
                                                    input logic [DATA_W-1:0] wdata,
                                                    input logic [2:0] off,
                                                    input logic [1:0] size);
    logic [7:0]        mask;
    logic [DATA_W-1:0] sh, res;
    case (size)
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    mask = mask << off;
    sh   = wdata << {off, 3'b000};
    res  = old;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) res[8*i +: 8] = sh[8*i +: 8];
    end
    return res;
  endfunction

  assign accept    = req_valid && req_ready;
  assign dw_addr   = {req_addr[ADDR_W-1:3], 3'b000};
  assign wait_done = (cnt_q == LAST_WAIT);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    misaligned = 1'b0;
    case (req_size)
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      2'd3:    misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

`ifdef LSU_FORWARD_EN
  logic              fwd_valid_q;
  logic [ADDR_W-1:0] fwd_addr_q;
  logic [DATA_W-1:0] fwd_data_q;

  // The buffer is a single entry, so it is cleared with the rest of the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
    end else if (state_q == WR) begin
      fwd_valid_q <= 1'b1;
      fwd_addr_q  <= mem_addr;
      fwd_data_q  <= mem_wdata;
    end
  end

  assign fwd_hit  = fwd_valid_q && (fwd_addr_q == dw_addr);
  assign fwd_data = fwd_data_q;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (misaligned)                  state_d = RESP;
          else if (!req_we)                state_d = fwd_hit ? RESP : RD_ISSUE;
          else if (req_size == 2'd3)       state_d = WR;
          else                             state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT:  if (wait_done) state_d = we_q ? WR : RESP;
      WR:       state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    req_ready  = (state_q == IDLE);
    mem_rd     = (state_q == RD_ISSUE);
    mem_wr     = (state_q == WR);
    resp_valid = (state_q == RESP);
  end

  // Request latch, memory address/data and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= '0;
      off_q      <= '0;
      wdata_q    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      cnt_q <= (state_q == RD_WAIT && !wait_done) ? cnt_q + 3'd1 : 3'd0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q       <= req_we;
            uns_q      <= req_unsigned;
            size_q     <= req_size;
            off_q      <= req_addr[2:0];
            wdata_q    <= req_wdata;
            mem_addr   <= dw_addr;
            resp_err   <= misaligned;
            resp_rdata <= '0;
            if (!misaligned && !req_we && fwd_hit)
              resp_rdata <= load_extend(fwd_data, req_addr[2:0], req_size, req_unsigned);
            if (req_we && req_size == 2'd3)
              mem_wdata <= req_wdata;
          end
        end
        RD_WAIT: begin
          if (wait_done) begin
            if (we_q) mem_wdata  <= store_merge(mem_rdata, wdata_q, off_q, size_q);
            else      resp_rdata <= load_extend(mem_rdata, off_q, size_q, uns_q);
          end
        end
        RESP: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
